// File: rtl/control_unit.sv
// control_unit -- Moore FSM sequencing the fetch / decode / execute cycle of
// the processor datapath.
//
// Also carries k_and_s_pkg, which defines the decoded instruction type shared
// with the datapath.
//
// Ports:
//   clk                  system clock, rising edge
//   rst_n                asynchronous active-low reset
//   decoded_instruction  current IR decode from the datapath
//   zero_op              registered zero flag
//   neg_op               registered negative flag
//   unsigned_overflow    registered carry flag (not used for any decision)
//   signed_overflow      registered overflow flag
//   branch               PC loads branch target instead of PC+1
//   pc_enable            PC register update
//   ir_enable            IR loads data_in
//   addr_sel             ram_addr source: 1=PC, 0=instruction address field
//   c_sel                register write source: 1=ALU, 0=data_in
//   operation            ALU op: 00=OR, 01=ADD, 10=SUB, 11=AND
//   write_reg_enable     register file write
//   flags_reg_enable     flag register update
//   ram_write_enable     RAM write of data_out
//   halt                 processor stopped

package k_and_s_pkg;
    // 5-bit encoding leaves unused codes, which the FSM treats as halt.
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;
endpackage

module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    typedef enum logic [3:0] {
        FETCH, DECODE, LOAD_1, STORE_1, MOVE_1, ALU_1, BRANCH_1, NEXT, HALT_ST
    } state_t;

    state_t     state, state_nx;
    logic [1:0] alu_op_q;
    logic [1:0] alu_op_dec;

    // The carry flag plays no part in any branch decision.
    logic unused_carry;
    assign unused_carry = unsigned_overflow;

    // ALU operation decoded from the live instruction; latched in DECODE so
    // ALU_1 is immune to the IR decode changing underneath it.
    always_comb begin
        alu_op_dec = 2'b00;
        unique case (decoded_instruction)
            I_ADD:   alu_op_dec = 2'b01;
            I_SUB:   alu_op_dec = 2'b10;
            I_AND:   alu_op_dec = 2'b11;
            default: alu_op_dec = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            alu_op_q <= 2'b00;
        end else begin
            state <= state_nx;
            if (state == DECODE)
                alu_op_q <= alu_op_dec;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FETCH:  state_nx = DECODE;
            DECODE: begin
                unique case (decoded_instruction)
                    I_LOAD:   state_nx = LOAD_1;
                    I_STORE:  state_nx = STORE_1;
                    I_MOVE:   state_nx = MOVE_1;
                    I_ADD, I_SUB, I_AND, I_OR: state_nx = ALU_1;
                    I_BRANCH: state_nx = BRANCH_1;
                    I_NOP:    state_nx = NEXT;
                    I_BZERO:  state_nx = zero_op          ? BRANCH_1 : NEXT;
                    I_BNZERO: state_nx = !zero_op         ? BRANCH_1 : NEXT;
                    I_BNEG:   state_nx = neg_op           ? BRANCH_1 : NEXT;
                    I_BNNEG:  state_nx = !neg_op          ? BRANCH_1 : NEXT;
                    I_BOV:    state_nx = signed_overflow  ? BRANCH_1 : NEXT;
                    I_BNOV:   state_nx = !signed_overflow ? BRANCH_1 : NEXT;
                    default:  state_nx = HALT_ST;
                endcase
            end
            LOAD_1, STORE_1, MOVE_1, ALU_1, BRANCH_1, NEXT: state_nx = FETCH;
            HALT_ST: state_nx = HALT_ST;
            default: state_nx = HALT_ST;
        endcase
    end

    // Outputs are gated by rst_n so they drop to zero the moment reset is
    // asserted, even though the state register itself rests in FETCH.
    always_comb begin
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = 2'b00;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        if (rst_n) begin
            unique case (state)
                FETCH: begin
                    ir_enable = 1'b1;
                    addr_sel  = 1'b1;
                end
                LOAD_1: begin
                    write_reg_enable = 1'b1;
                    pc_enable        = 1'b1;
                end
                STORE_1: begin
                    ram_write_enable = 1'b1;
                    pc_enable        = 1'b1;
                end
                MOVE_1: begin
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                    pc_enable        = 1'b1;
                end
                ALU_1: begin
                    operation        = alu_op_q;
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                    flags_reg_enable = 1'b1;
                    pc_enable        = 1'b1;
                end
                BRANCH_1: begin
                    branch    = 1'b1;
                    pc_enable = 1'b1;
                end
                NEXT:    pc_enable = 1'b1;
                HALT_ST: halt      = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed scenarios followed by randomized
// instruction/flag/reset traffic, checked against an instruction-level model
// (phase within instruction + what the decoded instruction means).
module tb_control_unit;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    decoded_instruction_type instr;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0] operation;
    logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;

    int vectors = 0;
    int miscompares = 0;

    control_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .decoded_instruction (instr),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .ram_write_enable    (ram_write_enable),
        .halt                (halt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 = fetch cycle, 1 = decode cycle, 2 = execute cycle
    localparam int K_LOAD = 0, K_STORE = 1, K_MOVE = 2, K_ALU = 3,
                   K_BR = 4, K_NEXT = 5;
    int         phase;
    bit         halted;
    int         kind;
    logic [1:0] cap_op;

    // {branch,pc,ir,addr,csel,op[1:0],wreg,flags,ramw,halt}
    function automatic logic [10:0] mk(bit br, bit pc, bit ir, bit as, bit cs,
                                        logic [1:0] op, bit wr, bit fl, bit rw, bit h);
        return {br, pc, ir, as, cs, op, wr, fl, rw, h};
    endfunction

    function automatic logic [10:0] expected();
        if (!rst_n) return '0;
        if (halted) return mk(0,0,0,0,0,2'b00,0,0,0,1);
        if (phase == 0) return mk(0,0,1,1,0,2'b00,0,0,0,0);
        if (phase == 1) return '0;
        case (kind)
            K_LOAD:  return mk(0,1,0,0,0,2'b00,1,0,0,0);
            K_STORE: return mk(0,1,0,0,0,2'b00,0,0,1,0);
            K_MOVE:  return mk(0,1,0,0,1,2'b00,1,0,0,0);
            K_ALU:   return mk(0,1,0,0,1,cap_op,1,1,0,0);
            K_BR:    return mk(1,1,0,0,0,2'b00,0,0,0,0);
            default: return mk(0,1,0,0,0,2'b00,0,0,0,0);
        endcase
    endfunction

    task automatic model_reset();
        phase  = 0;
        halted = 0;
    endtask

    // Advance the model across one rising edge using the inputs held there.
    task automatic model_step();
        if (!rst_n || halted) return;
        if (phase == 0) phase = 1;
        else if (phase == 2) phase = 0;
        else begin
            phase = 2;
            case (instr)
                I_LOAD:   kind = K_LOAD;
                I_STORE:  kind = K_STORE;
                I_MOVE:   kind = K_MOVE;
                I_ADD:    begin kind = K_ALU; cap_op = 2'b01; end
                I_SUB:    begin kind = K_ALU; cap_op = 2'b10; end
                I_AND:    begin kind = K_ALU; cap_op = 2'b11; end
                I_OR:     begin kind = K_ALU; cap_op = 2'b00; end
                I_BRANCH: kind = K_BR;
                I_NOP:    kind = K_NEXT;
                I_BZERO:  kind = (zero_op == 1)         ? K_BR : K_NEXT;
                I_BNZERO: kind = (zero_op == 0)         ? K_BR : K_NEXT;
                I_BNEG:   kind = (neg_op == 1)          ? K_BR : K_NEXT;
                I_BNNEG:  kind = (neg_op == 0)          ? K_BR : K_NEXT;
                I_BOV:    kind = (signed_overflow == 1) ? K_BR : K_NEXT;
                I_BNOV:   kind = (signed_overflow == 0) ? K_BR : K_NEXT;
                default:  halted = 1;
            endcase
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag);
        logic [10:0] act, exp;
        act = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable, halt};
        exp = expected();
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s: outputs got=%b want=%b (phase=%0d halted=%0d)",
                   tag, act, exp, phase, halted);
        end
        vectors++;
        assert (!(ram_write_enable === 1'b1 && write_reg_enable === 1'b1)) else begin
            miscompares++;
            $error("FAIL %s_excl: ram_we=%b wreg=%b want not both 1",
                   tag, ram_write_enable, write_reg_enable);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag);
    endtask

    // Called 1 time unit after a rising edge: pulse reset between edges.
    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check({tag, "_low"});
        #2 rst_n = 1'b1;
        #1 check({tag, "_released"});
    endtask

    // From a fetch cycle: run fetch->decode->execute->next.
    task automatic run_instr(input decoded_instruction_type i, input string tag);
        instr = i;
        tick({tag, "_decode"});
        tick({tag, "_exec"});
        tick({tag, "_after"});
    endtask

    task automatic randomize_inputs();
        int r;
        r = $urandom_range(0, 99);
        if (r < 2)      instr = I_HALT;
        else if (r < 4) instr = decoded_instruction_type'(5'($urandom_range(16, 31)));
        else            instr = decoded_instruction_type'(5'($urandom_range(0, 14)));
        zero_op           = 1'($urandom_range(0, 1));
        neg_op            = 1'($urandom_range(0, 1));
        unsigned_overflow = 1'($urandom_range(0, 1));
        signed_overflow   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int halt_cycles;
        rst_n = 1'b0;
        instr = I_NOP;
        zero_op = 0; neg_op = 0; unsigned_overflow = 0; signed_overflow = 0;
        phase = 0; halted = 0; kind = K_NEXT; cap_op = 2'b00;
        model_reset();

        #2 check("reset_hold");
        tick("reset_hold_edge1");
        tick("reset_hold_edge2");
        #5 rst_n = 1'b1;
        #1 check("fetch_after_release");

        // ADD: decode then ALU execute with op 01
        run_instr(I_ADD, "add");

        // BZERO taken then not taken; flags toggled during execute are ignored
        zero_op = 1;
        instr = I_BZERO;
        tick("bz_taken_decode");
        tick("bz_taken_exec");
        zero_op = 0;
        tick("bz_taken_after");
        run_instr(I_BZERO, "bz_not_taken");
        run_instr(I_BNEG, "bneg_nt");
        signed_overflow = 1;
        run_instr(I_BOV, "bov_t");
        run_instr(I_BNOV, "bnov_nt");

        run_instr(I_STORE, "store");
        run_instr(I_LOAD, "load");
        run_instr(I_MOVE, "move");

        // SUB latched in decode; live decode switches to AND during execute
        instr = I_SUB;
        tick("sub_decode");
        tick("sub_exec");
        instr = I_AND;
        #1 check("sub_op_held");
        tick("sub_after");

        // Async reset pulsed while in ALU_1
        instr = I_OR;
        tick("or_decode");
        tick("or_exec");
        reset_pulse("rst_in_alu");
        run_instr(I_NOP, "nop_after_rst");

        // HALT then 10 cycles of churning inputs
        run_instr(I_HALT, "halt");
        for (int c = 0; c < 10; c++) begin
            randomize_inputs();
            tick("halt_stay");
        end
        reset_pulse("rst_in_halt");
        run_instr(decoded_instruction_type'(5'd23), "unlisted");
        reset_pulse("rst_after_unlisted");

        // Randomized traffic with occasional async resets
        halt_cycles = 0;
        for (int c = 0; c < 800; c++) begin
            randomize_inputs();
            tick("random");
            halt_cycles = halted ? halt_cycles + 1 : 0;
            if (halt_cycles > 4 || $urandom_range(0, 99) < 2) begin
                reset_pulse("random_rst");
                halt_cycles = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Block SHALL have no parameters; all types SHALL come from k_and_s_pkg.
REQ-002 Clocking SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port list SHALL be as follows:
- clk  input  1  system clock, rising edge
- rst_n  input  1  async active-low reset
- decoded_instruction  input  decoded_instruction_type  current IR decode from the datapath
- zero_op  input  1  registered zero flag
- neg_op  input  1  registered negative flag
- unsigned_overflow  input  1  registered carry flag, ignored by this block
- signed_overflow  input  1  registered overflow flag
- branch  output  1  PC loads the branch target instead of PC+1
- pc_enable  output  1  PC register update
- ir_enable  output  1  IR loads data_in
- addr_sel  output  1  ram_addr source: 1=PC, 0=instruction address field
- c_sel  output  1  register write source: 1=ALU, 0=data_in
- operation  output  2  ALU op: 00=OR, 01=ADD, 10=SUB, 11=AND
- write_reg_enable  output  1  register file write
- flags_reg_enable  output  1  flag register update
- ram_write_enable  output  1  RAM write of data_out
- halt  output  1  processor stopped

Function
REQ-004 Block SHALL be a Moore FSM; all outputs SHALL decode from the state register only, and any output not listed for a state SHALL be 0.
REQ-005 States SHALL be FETCH, DECODE, LOAD_1, STORE_1, MOVE_1, ALU_1, BRANCH_1, NEXT, HALT_ST.
REQ-006 FETCH SHALL assert ir_enable=1 and addr_sel=1, then go to DECODE.
REQ-007 DECODE SHALL assert no outputs; next state SHALL come from decoded_instruction and flags sampled in that cycle:
- I_LOAD -> LOAD_1
- I_STORE -> STORE_1
- I_MOVE -> MOVE_1
- I_ADD, I_SUB, I_AND, I_OR -> ALU_1
- I_BRANCH -> BRANCH_1
- I_NOP -> NEXT
- I_HALT, or any unlisted value -> HALT_ST
REQ-008 Conditional branches in DECODE SHALL go to BRANCH_1 when taken and NEXT when not taken:
- I_BZERO taken when zero_op=1; I_BNZERO taken when zero_op=0
- I_BNEG taken when neg_op=1; I_BNNEG taken when neg_op=0
- I_BOV taken when signed_overflow=1; I_BNOV taken when signed_overflow=0
REQ-009 LOAD_1 SHALL assert addr_sel=0, c_sel=0, write_reg_enable=1, pc_enable=1, then go to FETCH.
REQ-010 STORE_1 SHALL assert addr_sel=0, ram_write_enable=1, pc_enable=1, then go to FETCH.
REQ-011 MOVE_1 SHALL assert operation=00, c_sel=1, write_reg_enable=1, flags_reg_enable=0, pc_enable=1, then go to FETCH.
REQ-012 ALU_1 SHALL assert c_sel=1, write_reg_enable=1, flags_reg_enable=1, pc_enable=1, with operation ADD=01, SUB=10, AND=11, OR=00, then go to FETCH.
REQ-013 ALU_1 SHALL take operation from the decoded_instruction value registered at DECODE, not the live input.
REQ-014 BRANCH_1 SHALL assert branch=1 and pc_enable=1, then go to FETCH.
REQ-015 NEXT SHALL assert pc_enable=1 and branch=0, then go to FETCH.
REQ-016 HALT_ST SHALL assert halt=1 with all other outputs 0, and SHALL stay in HALT_ST until reset.
REQ-017 Latency SHALL be 3 cycles per instruction (FETCH, DECODE, execute/NEXT); HALT SHALL reach halt=1 at cycle 3.
REQ-018 pc_enable SHALL be asserted exactly once per non-halt instruction.
REQ-019 ram_write_enable and write_reg_enable SHALL never both be 1 in the same cycle.
REQ-020 Flag changes outside DECODE SHALL have no effect on branch decisions.

Reset
REQ-021 rst_n=0 SHALL force state=FETCH immediately, asynchronously, with every output 0 while reset is held.
REQ-022 Reset asserted mid-instruction (any state, including HALT_ST) SHALL abort the instruction with no partial write asserted after the reset edge.
REQ-023 After rst_n deasserts, the first rising clk edge SHALL see FETCH outputs (ir_enable=1, addr_sel=1).
REQ-024 The registered operation SHALL reset to 00.

Verification
REQ-025 Release reset, drive I_ADD -> cycle1 ir_enable=1, addr_sel=1; cycle3 operation=01, c_sel=1, write_reg_enable=1, flags_reg_enable=1, pc_enable=1.
REQ-026 I_BZERO with zero_op=1, then zero_op=0 -> first: BRANCH_1 with branch=1, pc_enable=1; second: NEXT with branch=0, pc_enable=1.
REQ-027 I_STORE, then I_LOAD -> STORE_1: ram_write_enable=1, addr_sel=0, write_reg_enable=0; LOAD_1: c_sel=0, write_reg_enable=1, ram_write_enable=0.
REQ-028 I_HALT, then 10 more cycles with varying inputs -> halt=1 constant and pc_enable=0 throughout.
REQ-029 rst_n pulsed low mid-cycle during ALU_1 -> outputs go to 0 immediately without waiting for clk; FETCH follows the first edge after release.
REQ-030 I_SUB decoded, decoded_instruction changed to I_AND during ALU_1 -> operation stays 10.
